// File: rtl/toll_if.sv
// Vehicle-event bus between the booth sequencer and the toll-rate classifier:
// the qualified condition flags going in, the registered rate class and counters coming out.
interface toll_if #(
    parameter int CNT_W = 16
);
    logic             valid;
    logic             WD;
    logic             RH;
    logic             LN;
    logic             HT;
    logic             clr_cnt;
    logic             out_valid;
    logic             High;
    logic             Med;
    logic             Low;
    logic             Err;
    logic [CNT_W-1:0] cnt_high;
    logic [CNT_W-1:0] cnt_med;
    logic [CNT_W-1:0] cnt_low;
    logic [CNT_W-1:0] cnt_err;

    modport master (
        output valid, WD, RH, LN, HT, clr_cnt,
        input  out_valid, High, Med, Low, Err,
        input  cnt_high, cnt_med, cnt_low, cnt_err
    );

    modport slave (
        input  valid, WD, RH, LN, HT, clr_cnt,
        output out_valid, High, Med, Low, Err,
        output cnt_high, cnt_med, cnt_low, cnt_err
    );
endinterface

// File: rtl/toll_system.sv
// Toll-rate classifier: decodes the four vehicle condition flags into a registered
// one-hot rate class and keeps saturating per-class event counters.
module toll_system #(
    parameter int CNT_W = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    toll_if.slave  bus
);
    // One-hot bit positions inside class vectors.
    localparam int IDX_HIGH = 0;
    localparam int IDX_MED  = 1;
    localparam int IDX_LOW  = 2;
    localparam int IDX_ERR  = 3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Err has priority: rush hour outside weekdays or together with late night is impossible.
    function automatic logic [3:0] decode_class(input logic wd, input logic rh,
                                                input logic ln, input logic ht);
        logic [3:0] onehot;
        if ((rh & ~wd) | (rh & ln)) begin
            onehot = 4'b1000;
        end else if (rh | (ht & ~ln)) begin
            onehot = 4'b0001;
        end else if (ln & ~ht) begin
            onehot = 4'b0100;
        end else begin
            onehot = 4'b0010;
        end
        return onehot;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    logic [3:0]       class_s;
    logic [3:0]       class_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] cnt_nxt_s [4];
    logic [CNT_W-1:0] cnt_r     [4];

    // Decode the current flags into the one-hot rate class.
    always_comb begin
        class_s = decode_class(bus.WD, bus.RH, bus.LN, bus.HT);
    end

    // Next counter values: clear beats counting, otherwise bump the decoded class.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (bus.clr_cnt) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (bus.valid && class_s[i]) begin
                cnt_nxt_s[i] = sat_inc(cnt_r[i]);
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Register event strobe and class; the class holds between events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            class_r     <= 4'b0000;
        end else begin
            out_valid_r <= bus.valid;
            if (bus.valid) begin
                class_r <= class_s;
            end else begin
                class_r <= class_r;
            end
        end
    end

    // Register the per-class event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.High      = class_r[IDX_HIGH];
    assign bus.Med       = class_r[IDX_MED];
    assign bus.Low       = class_r[IDX_LOW];
    assign bus.Err       = class_r[IDX_ERR];
    assign bus.cnt_high  = cnt_r[IDX_HIGH];
    assign bus.cnt_med   = cnt_r[IDX_MED];
    assign bus.cnt_low   = cnt_r[IDX_LOW];
    assign bus.cnt_err   = cnt_r[IDX_ERR];
endmodule

// File: tb/tb_toll_system.sv
// Randomised and directed bench for toll_system: two instances (16-bit and 4-bit counters)
// share one stimulus stream and are checked every cycle against a truth-table model.
module tb_toll_system;
    logic clk;
    logic rst_n;
    logic s_valid, s_wd, s_rh, s_ln, s_ht, s_clr;

    toll_if #(.CNT_W(16)) bus16 ();
    toll_if #(.CNT_W(4))  bus4  ();

    assign bus16.valid = s_valid;  assign bus4.valid = s_valid;
    assign bus16.WD = s_wd;        assign bus4.WD = s_wd;
    assign bus16.RH = s_rh;        assign bus4.RH = s_rh;
    assign bus16.LN = s_ln;        assign bus4.LN = s_ln;
    assign bus16.HT = s_ht;        assign bus4.HT = s_ht;
    assign bus16.clr_cnt = s_clr;  assign bus4.clr_cnt = s_clr;

    toll_system #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    toll_system #(.CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: class from the 16-row truth table (code = WD RH LN HT), counters as ints.
    string tbl = "MHLMEEEEMHLMHHEE";
    bit    m_ov  = 1'b0;
    byte   m_cls = "-";
    int    m16 [4] = '{0, 0, 0, 0};
    int    m4  [4] = '{0, 0, 0, 0};

    function automatic int cls_idx(input byte c);
        case (c)
            "H": return 0;
            "M": return 1;
            "L": return 2;
            "E": return 3;
            default: return -1;
        endcase
    endfunction

    function automatic byte lookup(input logic wd, input logic rh, input logic ln, input logic ht);
        int code;
        code = {28'd0, wd, rh, ln, ht};
        return tbl[code];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ov  <= 1'b0;
            m_cls <= "-";
            for (int i = 0; i < 4; i++) begin
                m16[i] <= 0;
                m4[i]  <= 0;
            end
        end else begin
            m_ov <= s_valid;
            if (s_valid) m_cls <= lookup(s_wd, s_rh, s_ln, s_ht);
            for (int i = 0; i < 4; i++) begin
                if (s_clr) begin
                    m16[i] <= 0;
                    m4[i]  <= 0;
                end else if (s_valid && cls_idx(lookup(s_wd, s_rh, s_ln, s_ht)) == i) begin
                    m16[i] <= (m16[i] < 65535) ? m16[i] + 1 : 65535;
                    m4[i]  <= (m4[i] < 15) ? m4[i] + 1 : 15;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            chk("out_valid16", int'(bus16.out_valid), int'(m_ov));
            chk("out_valid4",  int'(bus4.out_valid),  int'(m_ov));
            chk("High", int'(bus16.High), int'(m_cls == "H"));
            chk("Med",  int'(bus16.Med),  int'(m_cls == "M"));
            chk("Low",  int'(bus16.Low),  int'(m_cls == "L"));
            chk("Err",  int'(bus16.Err),  int'(m_cls == "E"));
            chk("class4", int'({bus4.Err, bus4.Low, bus4.Med, bus4.High}),
                int'({bus16.Err, bus16.Low, bus16.Med, bus16.High}));
            chk("cnt_high16", int'(bus16.cnt_high), m16[0]);
            chk("cnt_med16",  int'(bus16.cnt_med),  m16[1]);
            chk("cnt_low16",  int'(bus16.cnt_low),  m16[2]);
            chk("cnt_err16",  int'(bus16.cnt_err),  m16[3]);
            chk("cnt_high4",  int'(bus4.cnt_high),  m4[0]);
            chk("cnt_med4",   int'(bus4.cnt_med),   m4[1]);
            chk("cnt_low4",   int'(bus4.cnt_low),   m4[2]);
            chk("cnt_err4",   int'(bus4.cnt_err),   m4[3]);
        end
    end

    task automatic drive(input logic v, input logic [3:0] code, input logic clr);
        s_valid = v;
        {s_wd, s_rh, s_ln, s_ht} = code;
        s_clr = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, int'(bus16.out_valid), 0);
        chk({tag, "_class"}, int'({bus16.Err, bus16.Low, bus16.Med, bus16.High}), 0);
        chk({tag, "_class4"}, int'({bus4.Err, bus4.Low, bus4.Med, bus4.High}), 0);
        chk({tag, "_cnt16"}, int'(bus16.cnt_high) + int'(bus16.cnt_med)
                             + int'(bus16.cnt_low) + int'(bus16.cnt_err), 0);
        chk({tag, "_cnt4"}, int'(bus4.cnt_high) + int'(bus4.cnt_med)
                            + int'(bus4.cnt_low) + int'(bus4.cnt_err), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        s_valid = 1'b0; s_wd = 1'b0; s_rh = 1'b0; s_ln = 1'b0; s_ht = 1'b0; s_clr = 1'b0;

        // Reset held with live random events: nothing may leak through.
        repeat (4) begin
            drive(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            chk_all_zero("rst_hold");
        end
        rst_n = 1'b1;
        check_en = 1'b1;
        drive(1'b1, 4'b1000, 1'b0);
        chk("post_rst_Med", int'(bus16.Med), 1);
        chk("post_rst_out_valid", int'(bus16.out_valid), 1);
        chk("post_rst_cnt_med", int'(bus16.cnt_med), 1);

        // Exhaustive sweep of all 16 codes from cleared counters.
        drive(1'b0, 4'b0000, 1'b1);
        for (int c = 0; c < 16; c++) drive(1'b1, 4'(c), 1'b0);
        chk("sweep_high", int'(bus16.cnt_high), 4);
        chk("sweep_med",  int'(bus16.cnt_med),  4);
        chk("sweep_low",  int'(bus16.cnt_low),  2);
        chk("sweep_err",  int'(bus16.cnt_err),  6);
        chk("model_sweep_err", m16[3], 6);
        chk("sweep_last_Err", int'(bus16.Err), 1);

        // Hold: flags toggle with valid low, class and counters must freeze.
        drive(1'b1, 4'b1001, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, 4'(k * 3 + 2), 1'b0);
        chk("hold_High", int'(bus16.High), 1);
        chk("hold_out_valid", int'(bus16.out_valid), 0);
        chk("hold_cnt_high", int'(bus16.cnt_high), 5);

        // Saturation of the 4-bit instance.
        drive(1'b0, 4'b0000, 1'b1);
        repeat (20) drive(1'b1, 4'b0010, 1'b0);
        chk("sat_low4", int'(bus4.cnt_low), 15);
        chk("sat_low16", int'(bus16.cnt_low), 20);
        chk("sat_others4", int'(bus4.cnt_high) + int'(bus4.cnt_med) + int'(bus4.cnt_err), 0);

        // Clear colliding with an event: clear wins for the counters only.
        drive(1'b1, 4'b1110, 1'b1);
        chk("clr_Err", int'(bus16.Err), 1);
        chk("clr_out_valid", int'(bus16.out_valid), 1);
        chk("clr_cnt_err", int'(bus16.cnt_err), 0);
        chk("clr_cnt_low", int'(bus16.cnt_low), 0);
        drive(1'b1, 4'b1110, 1'b0);
        chk("clr_next_cnt_err", int'(bus16.cnt_err), 1);

        // Random stream with an asynchronous reset pulse in the middle.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #1 rst_n = 1'b0;
                #1 chk_all_zero("async_rst");
                rst_n = 1'b1;
            end
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 24) == 0));
        end
        drive(1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/toll_system.md
Name: toll_system

Overview:
- Registered toll-rate classifier for a toll booth controller.
- Each accepted vehicle event is described by four condition flags: weekday, rush hour, late night and heavy truck.
- The block decodes the flags into exactly one one-hot rate class: High, Med, Low or Err (invalid flag combination).
- It keeps saturating per-class event counters for the billing/statistics block downstream.

Parameters:
- CNT_W, 16, width of each per-class event counter.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- valid  input  1  qualifies WD/RH/LN/HT as a new vehicle event this cycle.
- WD  input  1  weekday flag (1 = weekday).
- RH  input  1  rush-hour flag.
- LN  input  1  late-night flag.
- HT  input  1  heavy-truck flag.
- clr_cnt  input  1  synchronous clear of all four counters.
- out_valid  output  1  registered; high for one cycle per accepted event.
- High  output  1  registered rate-class output, high rate.
- Med  output  1  registered rate-class output, medium rate.
- Low  output  1  registered rate-class output, low rate.
- Err  output  1  registered rate-class output, invalid flag combination.
- cnt_high, cnt_med, cnt_low, cnt_err  output  CNT_W each  events per class since reset or last clear.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asserted asynchronously):
  - out_valid, High, Med, Low, Err all 0.
  - All counters 0.
  - Release is synchronous to clk.
- Classification, combinational on the inputs and evaluated in this priority order:
  - Err = (RH & ~WD) | (RH & LN). Rush hour exists only on weekdays and never coincides with late night.
  - else High = RH | (HT & ~LN).
  - else Low = LN & ~HT.
  - else Med.
- Full truth table (WD RH LN HT -> class):
  - 0000 Med, 0001 High, 0010 Low, 0011 Med.
  - 0100 Err, 0101 Err, 0110 Err, 0111 Err.
  - 1000 Med, 1001 High, 1010 Low, 1011 Med.
  - 1100 High, 1101 High, 1110 Err, 1111 Err.
- Latency: 1 cycle. On a rising edge with valid=1:
  - The class outputs load the decoded one-hot value.
  - out_valid is set to 1.
- On a rising edge with valid=0:
  - out_valid=0.
  - The class outputs hold their previous value.
- One-hot invariant: after the first accepted event, exactly one of High/Med/Low/Err is 1. After reset and before any event, all four are 0.
- Counters: on each accepted event, the counter matching the decoded class increments by 1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Counters update on the same edge as the class outputs.
- clr_cnt=1 at an edge zeroes all counters. If valid is also 1 at that edge:
  - Clear wins for the counters; the event is not counted.
  - The class outputs and out_valid still update normally.
- Inputs are sampled only when valid=1. Flag changes while valid=0 have no effect.
- Asserting reset mid-stream immediately zeroes all outputs and counters, regardless of the clock.
- No handshake backpressure; the block accepts one event every cycle.

Test Plan:
- Reset: hold rst_n=0 with valid=1 and random flags -> all class outputs, out_valid and counters stay 0. Release, then WD=1 RH=0 LN=0 HT=0 valid=1 -> one cycle later Med=1, out_valid=1, cnt_med=1.
- Exhaustive sweep: apply all 16 WD/RH/LN/HT codes in ascending order, valid=1 each cycle.
  - Each output matches the truth table one cycle later.
  - Final counts: cnt_high=4, cnt_med=4, cnt_low=2, cnt_err=6.
- Hold: after an event of code 1001 (High), drop valid and toggle the flags for 5 cycles -> High stays 1, out_valid=0, counters unchanged.
- Saturation: with CNT_W=4, apply 20 consecutive code-0010 events -> cnt_low=15 and holds at 15; other counters stay 0.
- Clear collision: assert clr_cnt and valid together with code 1110 -> all counters 0, Err=1, out_valid=1. The next code-1110 event gives cnt_err=1.
- Async reset mid-operation: pulse rst_n low between clock edges during a stream -> outputs and counters go to 0 before the next edge; the stream resumes correctly after release.
